// File: rtl/if_fetch_controller.sv
// IF-stage sequencing controller: instruction-memory wait countdown, hazard freeze,
// branch redirect with queuing while the MEM stage owns the shared SRAM port.
module if_fetch_controller #(
  parameter int unsigned IMEM_WAIT = 2,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned STALL_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_in,
  input  logic               mem_stall_in,
  input  logic               branch_taken_in,
  input  logic [31:0]        branch_addr_in,
  output logic               freeze_out,
  output logic               flush_out,
  output logic               branch_taken_out,
  output logic [31:0]        branch_addr_out,
  output logic               fetch_valid_out,
  output logic [STALL_W-1:0] stall_count_out
);

  localparam logic [CNT_W-1:0] WaitInit = CNT_W'(IMEM_WAIT);

  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               pend_valid_q, pend_valid_d;
  logic [31:0]        pend_addr_q, pend_addr_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic        redirect_req;
  logic [31:0] redirect_addr;
  logic        do_redirect;
  logic        freeze;
  logic        fetch_valid;

  always_comb begin
    redirect_req  = pend_valid_q | branch_taken_in;
    redirect_addr = pend_valid_q ? pend_addr_q : branch_addr_in;
    // MEM ownership of the port beats a redirect; a redirect beats a hazard.
    do_redirect   = rst & redirect_req & ~mem_stall_in;
    freeze        = ~rst |
                    (~do_redirect & (mem_stall_in | hazard_in | (wait_cnt_q != '0)));
    fetch_valid   = rst & ~freeze & ~do_redirect;

    freeze_out       = freeze;
    flush_out        = do_redirect;
    branch_taken_out = do_redirect;
    branch_addr_out  = do_redirect ? redirect_addr : 32'd0;
    fetch_valid_out  = fetch_valid;
    stall_count_out  = stall_cnt_q;
  end

  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    stall_cnt_d  = stall_cnt_q;

    if (do_redirect || fetch_valid) begin
      wait_cnt_d = WaitInit;
    end else if ((wait_cnt_q != '0) && !mem_stall_in) begin
      wait_cnt_d = wait_cnt_q - CNT_W'(1);
    end

    // Oldest branch wins; any branch arriving while one is queued is wrong-path.
    if (do_redirect) begin
      pend_valid_d = 1'b0;
    end else if (branch_taken_in && mem_stall_in && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = branch_addr_in;
    end

    if (freeze && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q   <= WaitInit;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 32'd0;
      stall_cnt_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_controller.sv
// Directed bench for if_fetch_controller (IMEM_WAIT=2, STALL_W=4); inputs change on the
// falling edge and outputs are sampled 1ns later.
module tb_if_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_in, mem_stall_in, branch_taken_in;
  logic [31:0] branch_addr_in;
  logic        freeze_out, flush_out, branch_taken_out, fetch_valid_out;
  logic [31:0] branch_addr_out;
  logic [3:0]  stall_count_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_controller #(
    .IMEM_WAIT(2),
    .CNT_W    (4),
    .STALL_W  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_in       (hazard_in),
    .mem_stall_in    (mem_stall_in),
    .branch_taken_in (branch_taken_in),
    .branch_addr_in  (branch_addr_in),
    .freeze_out      (freeze_out),
    .flush_out       (flush_out),
    .branch_taken_out(branch_taken_out),
    .branch_addr_out (branch_addr_out),
    .fetch_valid_out (fetch_valid_out),
    .stall_count_out (stall_count_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic fr, input logic fl, input logic bt,
                      input logic [31:0] addr, input logic fv);
    chk({tag, ".freeze"}, {31'd0, freeze_out}, {31'd0, fr});
    chk({tag, ".flush"}, {31'd0, flush_out}, {31'd0, fl});
    chk({tag, ".br_taken"}, {31'd0, branch_taken_out}, {31'd0, bt});
    chk({tag, ".br_addr"}, branch_addr_out, addr);
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid_out}, {31'd0, fv});
  endtask

  // Advance to the next falling edge; inputs are then set and sampled after #1.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; hazard_in = 1'b0; mem_stall_in = 1'b0;
    branch_taken_in = 1'b0; branch_addr_in = 32'd0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      outs("rst", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("rst.stall_cnt", {28'd0, stall_count_out}, 32'd0);
    end

    // Release: freeze 1,1,0 repeating, fetch every 3rd cycle
    tick(); rst = 1'b1; #1;
    for (int p = 0; p < 2; p++) begin
      outs("rel.w2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      tick(); #1;
      outs("rel.w1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      tick(); #1;
      outs("rel.fetch", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      if (p == 0) chk("rel.stall_cnt", {28'd0, stall_count_out}, 32'd2);
      tick(); #1;
    end

    // Hazard for 4 cycles from wait_cnt=2; countdown continues underneath
    hazard_in = 1'b1; #1;
    outs("haz0", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); #1; outs("haz1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); #1; outs("haz2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); #1; outs("haz3", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); hazard_in = 1'b0; #1;
    outs("haz.release", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Direct redirect at wait_cnt=1 under hazard
    tick(); #1; outs("dir.w2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); hazard_in = 1'b1; branch_taken_in = 1'b1; branch_addr_in = 32'h40; #1;
    outs("dir.redirect", 1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    tick(); hazard_in = 1'b0; branch_taken_in = 1'b0; branch_addr_in = 32'd0; #1;
    outs("dir.after1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); #1; outs("dir.after2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); #1; outs("dir.fetch", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Stalled redirect: 0x80 queued, 0xC0 dropped, issued once stall ends
    tick(); mem_stall_in = 1'b1; branch_taken_in = 1'b1; branch_addr_in = 32'h80; #1;
    outs("stl.c0", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); branch_addr_in = 32'hC0; #1;
    outs("stl.c1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); branch_taken_in = 1'b0; branch_addr_in = 32'd0; #1;
    outs("stl.c2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); #1; outs("stl.c3", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); mem_stall_in = 1'b0; #1;
    outs("stl.c4", 1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
    tick(); #1; outs("stl.c5", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); #1; outs("stl.c6", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); #1; outs("stl.c7", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Pending redirect discarded by reset
    tick(); mem_stall_in = 1'b1; branch_taken_in = 1'b1; branch_addr_in = 32'h100; #1;
    outs("prst.cap", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); branch_taken_in = 1'b0; branch_addr_in = 32'd0; rst = 1'b0; #1;
    outs("prst.rst", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); rst = 1'b1; mem_stall_in = 1'b0; #1;
    outs("prst.w2", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); #1; outs("prst.w1", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tick(); #1; outs("prst.fetch", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("prst.stall_cnt", {28'd0, stall_count_out}, 32'd2);

    // Saturation of the 4-bit stall counter under 20 cycles of MEM ownership
    for (int k = 0; k < 20; k++) begin
      tick(); mem_stall_in = 1'b1; #1;
      if (k == 5)  chk("sat.climb", {28'd0, stall_count_out}, 32'd7);
      if (k == 13) chk("sat.reach", {28'd0, stall_count_out}, 32'd15);
      if (k == 19) begin
        chk("sat.hold", {28'd0, stall_count_out}, 32'd15);
        outs("sat.outs", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      end
    end
    tick(); mem_stall_in = 1'b0; #1;
    chk("sat.after", {28'd0, stall_count_out}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch_controller.md
Name: if_fetch_controller

Overview:
- Sequencing controller for the IF stage and IF/ID register.
- Generates freeze, flush and branch-redirect controls from three inputs: a fixed-latency instruction-memory wait counter, ID-stage data hazards, and EXE-stage taken branches.
- The instruction SRAM port is shared with the MEM stage. While the MEM stage owns it (mem_stall_in), fetch pauses and redirects are queued until the port is released.

Parameters:
- IMEM_WAIT, 2, wait cycles per fetch before the instruction is valid (0..2^CNT_W-1); 0 means single-cycle fetch.
- CNT_W, 4, width of the wait counter.
- STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- hazard_in  in  1  ID-stage data hazard; PC and IF/ID must hold.
- mem_stall_in  in  1  MEM stage owns the SRAM port this cycle.
- branch_taken_in  in  1  EXE-stage taken branch, one-cycle pulse.
- branch_addr_in  in  32  branch target, valid with branch_taken_in.
- freeze_out  out  1  to IF stage and IF/ID register: hold PC and register.
- flush_out  out  1  to IF/ID register: load bubble.
- branch_taken_out  out  1  to IF stage: load PC from branch_addr_out.
- branch_addr_out  out  32  redirect target.
- fetch_valid_out  out  1  instruction accepted into IF/ID this cycle.
- stall_count_out  out  STALL_W  cycles with freeze_out=1 since reset, saturating.

Behaviour:
- State registers: wait_cnt[CNT_W], pend_valid, pend_addr[32], stall_cnt[STALL_W].
- Reset (rst=0, async):
  - wait_cnt=IMEM_WAIT, pend_valid=0, pend_addr=0, stall_cnt=0.
  - While rst=0, outputs forced to freeze_out=1, flush_out=0, branch_taken_out=0, branch_addr_out=0, fetch_valid_out=0.
  - Reset mid-wait or with a pending redirect discards both.
- Combinational (rst=1):
  - redirect_req = pend_valid | branch_taken_in.
  - redirect_addr = pend_valid ? pend_addr : branch_addr_in.
  - do_redirect = redirect_req & ~mem_stall_in.
  - branch_taken_out = flush_out = do_redirect.
  - branch_addr_out = do_redirect ? redirect_addr : 0.
  - freeze_out = ~do_redirect & (mem_stall_in | hazard_in | wait_cnt!=0).
  - fetch_valid_out = ~freeze_out & ~do_redirect.
- Priority:
  - Redirect beats hazard: wrong-path instructions are squashed, so freeze_out=0 in the redirect cycle.
  - mem_stall_in beats redirect.
- Sequential, one branch evaluated per clock in this order:
  - do_redirect: wait_cnt<=IMEM_WAIT (in-flight fetch aborted); pend_valid<=0.
  - else fetch_valid_out: wait_cnt<=IMEM_WAIT (next fetch begins).
  - else wait_cnt!=0 & ~mem_stall_in: wait_cnt<=wait_cnt-1. Hazard does not pause the countdown; MEM ownership does.
  - else: wait_cnt holds. An instruction ready (wait_cnt=0) under hazard is held, not refetched.
- Pending capture:
  - branch_taken_in & mem_stall_in & ~pend_valid: pend_valid<=1, pend_addr<=branch_addr_in.
  - branch_taken_in while pend_valid=1 (stalled or in the redirect cycle): dropped. The oldest branch wins; later ones are wrong-path.
- Effective states:
  - READY: wait_cnt=0, pend_valid=0.
  - WAIT: wait_cnt>0.
  - PEND: pend_valid=1.
  - PEND resolves in the first cycle with mem_stall_in=0.
- IMEM_WAIT=0: wait_cnt is always 0; fetch_valid_out=1 on every cycle without hazard, stall or redirect.
- stall_cnt increments on each clock with freeze_out=1 (including reset release cycles) and saturates at 2^STALL_W-1.
- Latency: redirect to PC load is 0 cycles (same cycle as the request) when unstalled. With IMEM_WAIT=N and no stalls, the first fetch_valid_out after reset release or redirect arrives N cycles later.

Test Plan (IMEM_WAIT=2):
- Reset: hold rst=0 for 3 cycles, then release with no stimulus. Required: freeze_out=1 and other outputs 0 during reset. freeze_out follows 1,1,0 repeating. fetch_valid_out pulses every 3rd cycle. stall_count_out=2 after the first fetch.
- Hazard hold: hazard_in=1 for 4 cycles starting at wait_cnt=2. Required: countdown continues to 0. freeze_out=1 for all 4 cycles. fetch_valid_out=1 in the first cycle after hazard_in falls. No extra wait cycles.
- Direct redirect: branch_taken_in=1, branch_addr_in=0x40 while wait_cnt=1 and hazard_in=1. Required, same cycle: branch_taken_out=1, flush_out=1, freeze_out=0, branch_addr_out=0x40. Next two cycles: freeze_out=1 (wait_cnt reloaded to 2).
- Stalled redirect: mem_stall_in=1 for cycles 0-3; branch 0x80 in cycle 0, branch 0xC0 in cycle 1. Required: no redirect and freeze_out=1 in cycles 0-3. In cycle 4: exactly one redirect to 0x80. 0xC0 never appears. pend_valid=0 afterward.
- Pending plus reset: capture branch 0x100 under mem_stall_in, then pulse rst=0 for one cycle, then drop mem_stall_in. Required: no redirect is ever issued; the normal reset sequence follows.
- Saturation (STALL_W=4): hold mem_stall_in=1 for 20 cycles. Required: stall_count_out climbs to 15 and holds.
